// File: rtl/rot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rot_pkg
//  Description : Shared definitions for the rotation search block.
//                - Rotation command codes applied to the tmp faces.
//                - Search controller state encoding.
//                - Default store beat count and maximum search depth.
//                The imem microcode and the datapath also use this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package rot_pkg;

    // Store beats per result: blue, white, red, order1, order2
    localparam int c_store_words_def = 5;

    // Longest rotation sequence tried (legal values 1..2)
    localparam int c_max_depth_def   = 2;

    // Rotation command codes
    localparam logic [2:0] c_rot_x90  = 3'd0;
    localparam logic [2:0] c_rot_x180 = 3'd1;
    localparam logic [2:0] c_rot_x270 = 3'd2;
    localparam logic [2:0] c_rot_y90  = 3'd3;
    localparam logic [2:0] c_rot_y180 = 3'd4;
    localparam logic [2:0] c_rot_y270 = 3'd5;
    localparam logic [2:0] c_rot_z90  = 3'd6;
    localparam logic [2:0] c_rot_z180 = 3'd7;

    // Highest code; each odometer digit wraps after this value
    localparam logic [2:0] c_rot_last = c_rot_z180;

    // Search controller state encoding
    localparam int         c_state_w  = 4;
    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_init  = 4'd1;
    localparam logic [3:0] c_st_rot1  = 4'd2;
    localparam logic [3:0] c_st_wait1 = 4'd3;
    localparam logic [3:0] c_st_rot2  = 4'd4;
    localparam logic [3:0] c_st_wait2 = 4'd5;
    localparam logic [3:0] c_st_cmp   = 4'd6;
    localparam logic [3:0] c_st_eval  = 4'd7;
    localparam logic [3:0] c_st_store = 4'd8;
    localparam logic [3:0] c_st_done  = 4'd9;

endpackage : rot_pkg
`default_nettype wire

// File: rtl/rot_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rot_seq_counter
//  Description : Candidate odometer for the rotation search.
//                Walks depth 0, then depth 1 (seq1 = 0..7), then depth 2
//                (seq1,seq2 = 0,0 .. 7,7) with seq2 as the fastest digit.
//                exhausted is high when the current candidate is the last
//                one at MAX_DEPTH; an advance in that case leaves the
//                counter holding the final candidate.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                clear         - restart at depth 0 (seq1 = seq2 = 0)
//                advance       - step to the next candidate
//                seq1, seq2    - rotation codes of the current candidate
//                depth         - number of rotations in the candidate
//                exhausted     - current candidate is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_seq_counter
    import rot_pkg::*;
#(
    parameter int MAX_DEPTH = c_max_depth_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] seq1,
    output logic [2:0] seq2,
    output logic [1:0] depth,
    output logic       exhausted
);

    localparam logic [1:0] c_max_depth = 2'(MAX_DEPTH);

    logic [2:0] r_seq1;
    logic [2:0] r_seq2;
    logic [1:0] r_depth;
    logic       w_last_at_depth;

    // Last candidate of the current depth; depth 0 has a single candidate
    always_comb begin
        w_last_at_depth = 1'b1;
        case (r_depth)
            2'd0:    w_last_at_depth = 1'b1;
            2'd1:    w_last_at_depth = (r_seq1 == c_rot_last);
            default: w_last_at_depth = (r_seq1 == c_rot_last) && (r_seq2 == c_rot_last);
        endcase
    end

    assign exhausted = w_last_at_depth && (r_depth == c_max_depth);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq1  <= 3'd0;
            r_seq2  <= 3'd0;
            r_depth <= 2'd0;
        end else if (clear) begin
            r_seq1  <= 3'd0;
            r_seq2  <= 3'd0;
            r_depth <= 2'd0;
        end else if (advance && !exhausted) begin
            case (r_depth)
                2'd0: begin
                    r_depth <= 2'd1;
                    r_seq1  <= 3'd0;
                    r_seq2  <= 3'd0;
                end
                2'd1: begin
                    if (r_seq1 == c_rot_last) begin
                        r_depth <= 2'd2;
                        r_seq1  <= 3'd0;
                        r_seq2  <= 3'd0;
                    end else begin
                        r_seq1  <= r_seq1 + 3'd1;
                    end
                end
                default: begin
                    // seq1 cannot wrap here: that case is flagged exhausted
                    if (r_seq2 == c_rot_last) begin
                        r_seq2 <= 3'd0;
                        r_seq1 <= r_seq1 + 3'd1;
                    end else begin
                        r_seq2 <= r_seq2 + 3'd1;
                    end
                end
            endcase
        end
    end

    assign seq1  = r_seq1;
    assign seq2  = r_seq2;
    assign depth = r_depth;

endmodule : rot_seq_counter
`default_nettype wire

// File: rtl/rot_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rot_search_ctrl
//  Description : Brute-force rotation search controller. For each candidate
//                sequence it reloads the tmp faces, issues the candidate's
//                rotations, requests a compare and, on a match, streams the
//                result out as STORE_WORDS store beats. All outputs are
//                registered.
//  Ports       : clk, rst_n            - clock, synchronous active-low reset
//                start                 - begin a search (IDLE only)
//                load_init             - reload tmp faces (1-cycle pulse)
//                rot_valid/rot_code    - rotation command, rot_ready accepts
//                rot_done              - rotation written back (1-cycle)
//                cmp_en / match        - compare request / result next cycle
//                store_req/store_idx   - store beat, store_ack accepts
//                seq1, seq2, depth     - current / final candidate
//                busy, found, fail     - status; found/fail are sticky
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_search_ctrl
    import rot_pkg::*;
#(
    parameter int STORE_WORDS = c_store_words_def,
    parameter int MAX_DEPTH   = c_max_depth_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       load_init,
    output logic       rot_valid,
    output logic [2:0] rot_code,
    input  logic       rot_ready,
    input  logic       rot_done,
    output logic       cmp_en,
    input  logic       match,
    output logic       store_req,
    output logic [2:0] store_idx,
    input  logic       store_ack,
    output logic [2:0] seq1,
    output logic [2:0] seq2,
    output logic [1:0] depth,
    output logic       busy,
    output logic       found,
    output logic       fail
);

    localparam logic [2:0] c_last_idx = 3'(STORE_WORDS - 1);

    logic [c_state_w-1:0] r_state;
    logic                 r_load_init;
    logic                 r_rot_valid;
    logic [2:0]           r_rot_code;
    logic                 r_cmp_en;
    logic                 r_store_req;
    logic [2:0]           r_store_idx;
    logic                 r_busy;
    logic                 r_found;
    logic                 r_fail;

    logic                 w_clear;
    logic                 w_advance;
    logic                 w_exhausted;
    logic [2:0]           w_seq1;
    logic [2:0]           w_seq2;
    logic [1:0]           w_depth;

    // The odometer restarts on an accepted start and steps on every miss;
    // its registers update on the same edge the FSM leaves IDLE / EVAL.
    assign w_clear   = (r_state == c_st_idle) && start;
    assign w_advance = (r_state == c_st_eval) && !match;

    rot_seq_counter #(
        .MAX_DEPTH (MAX_DEPTH)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .advance   (w_advance),
        .seq1      (w_seq1),
        .seq2      (w_seq2),
        .depth     (w_depth),
        .exhausted (w_exhausted)
    );

    // Outputs are set on the transition into the state that owns them, so
    // each strobe is high exactly while the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_load_init <= 1'b0;
            r_rot_valid <= 1'b0;
            r_rot_code  <= 3'd0;
            r_cmp_en    <= 1'b0;
            r_store_req <= 1'b0;
            r_store_idx <= 3'd0;
            r_busy      <= 1'b0;
            r_found     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_load_init <= 1'b0;
            r_cmp_en    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_init;
                        r_load_init <= 1'b1;
                        r_busy      <= 1'b1;
                        r_found     <= 1'b0;
                        r_fail      <= 1'b0;
                    end
                end
                c_st_init: begin
                    if (w_depth >= 2'd1) begin
                        r_state     <= c_st_rot1;
                        r_rot_valid <= 1'b1;
                        r_rot_code  <= w_seq1;
                    end else begin
                        r_state     <= c_st_cmp;
                        r_cmp_en    <= 1'b1;
                    end
                end
                c_st_rot1: begin
                    if (rot_ready) begin
                        r_state     <= c_st_wait1;
                        r_rot_valid <= 1'b0;
                    end
                end
                c_st_wait1: begin
                    if (rot_done) begin
                        if (w_depth == 2'd2) begin
                            r_state     <= c_st_rot2;
                            r_rot_valid <= 1'b1;
                            r_rot_code  <= w_seq2;
                        end else begin
                            r_state     <= c_st_cmp;
                            r_cmp_en    <= 1'b1;
                        end
                    end
                end
                c_st_rot2: begin
                    if (rot_ready) begin
                        r_state     <= c_st_wait2;
                        r_rot_valid <= 1'b0;
                    end
                end
                c_st_wait2: begin
                    if (rot_done) begin
                        r_state  <= c_st_cmp;
                        r_cmp_en <= 1'b1;
                    end
                end
                c_st_cmp: begin
                    r_state <= c_st_eval;
                end
                c_st_eval: begin
                    if (match) begin
                        r_state     <= c_st_store;
                        r_store_req <= 1'b1;
                        r_store_idx <= 3'd0;
                    end else if (w_exhausted) begin
                        r_state <= c_st_done;
                        r_fail  <= 1'b1;
                    end else begin
                        r_state     <= c_st_init;
                        r_load_init <= 1'b1;
                    end
                end
                c_st_store: begin
                    if (store_ack) begin
                        if (r_store_idx == c_last_idx) begin
                            r_state     <= c_st_done;
                            r_store_req <= 1'b0;
                            r_store_idx <= 3'd0;
                            r_found     <= 1'b1;
                        end else begin
                            r_store_idx <= r_store_idx + 3'd1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_rot_valid <= 1'b0;
                    r_store_req <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign load_init = r_load_init;
    assign rot_valid = r_rot_valid;
    assign rot_code  = r_rot_code;
    assign cmp_en    = r_cmp_en;
    assign store_req = r_store_req;
    assign store_idx = r_store_idx;
    assign seq1      = w_seq1;
    assign seq2      = w_seq2;
    assign depth     = w_depth;
    assign busy      = r_busy;
    assign found     = r_found;
    assign fail      = r_fail;

endmodule : rot_search_ctrl
`default_nettype wire

// File: tb/tb_rot_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rot_search_ctrl
//  Description : Directed bench for rot_search_ctrl. A small datapath model
//                records the rotations applied since the last load_init and
//                answers each compare by matching that history against a
//                target sequence chosen per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       load_init;
    logic       rot_valid;
    logic [2:0] rot_code;
    logic       rot_ready = 1'b0;
    logic       rot_done = 1'b0;
    logic       cmp_en;
    logic       match = 1'b0;
    logic       store_req;
    logic [2:0] store_idx;
    logic       store_ack = 1'b0;
    logic [2:0] seq1;
    logic [2:0] seq2;
    logic [1:0] depth;
    logic       busy;
    logic       found;
    logic       fail;

    int n_checks = 0;
    int n_errors = 0;

    // datapath model state
    int         tgt_len = 0;
    logic [2:0] tgt [2];
    int         hist_len = 0;
    logic [2:0] hist [2];
    int         cnt_cmp = 0, cnt_rot = 0, cnt_store = 0, cnt_load = 0;
    int         stab_err = 0, seq_err = 0;
    int         stall_cnt = 0, ack_gap = 0, ack_wait = 0, pend = 0;
    bit         cmp_prev = 0, match_val = 0, prev_wait = 0, swait = 0;
    logic [2:0] prev_code = 3'd0, sidx_prev = 3'd0;

    rot_search_ctrl #(
        .STORE_WORDS (5),
        .MAX_DEPTH   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_init (load_init),
        .rot_valid (rot_valid),
        .rot_code  (rot_code),
        .rot_ready (rot_ready),
        .rot_done  (rot_done),
        .cmp_en    (cmp_en),
        .match     (match),
        .store_req (store_req),
        .store_idx (store_idx),
        .store_ack (store_ack),
        .seq1      (seq1),
        .seq2      (seq2),
        .depth     (depth),
        .busy      (busy),
        .found     (found),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    // Datapath / store sink model, evaluated mid-cycle
    always @(negedge clk) begin
        match = cmp_prev ? match_val : 1'b0;
        if (cmp_en) begin
            cnt_cmp++;
            match_val = (hist_len == tgt_len);
            for (int i = 0; i < 2; i++)
                if (i < tgt_len && i < hist_len && hist[i] != tgt[i]) match_val = 0;
        end
        cmp_prev = cmp_en;

        if (load_init) begin
            hist_len = 0;
            cnt_load++;
        end

        rot_done = (pend == 1);
        if (pend > 0) pend--;

        if (rot_valid) begin
            if (prev_wait && rot_code != prev_code) stab_err++;
            if (stall_cnt > 0) begin
                rot_ready = 1'b0;
                stall_cnt--;
                prev_wait = 1;
                prev_code = rot_code;
            end else begin
                rot_ready = 1'b1;
                cnt_rot++;
                if (hist_len < 2) hist[hist_len] = rot_code;
                hist_len++;
                pend = 4;
                prev_wait = 0;
            end
        end else begin
            if (prev_wait) stab_err++;
            rot_ready = 1'b0;
            prev_wait = 0;
        end

        if (store_req) begin
            if (swait && store_idx != sidx_prev) stab_err++;
            if (ack_wait > 0) begin
                store_ack = 1'b0;
                ack_wait--;
                swait = 1;
                sidx_prev = store_idx;
            end else begin
                store_ack = 1'b1;
                if (32'(store_idx) != cnt_store) seq_err++;
                cnt_store++;
                ack_wait = ack_gap;
                swait = 0;
            end
        end else begin
            if (swait) stab_err++;
            store_ack = 1'b0;
            swait = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_found"},     32'(found),     0);
        chk({tag, "_fail"},      32'(fail),      0);
        chk({tag, "_load_init"}, 32'(load_init), 0);
        chk({tag, "_rot_valid"}, 32'(rot_valid), 0);
        chk({tag, "_cmp_en"},    32'(cmp_en),    0);
        chk({tag, "_store_req"}, 32'(store_req), 0);
        chk({tag, "_rot_code"},  32'(rot_code),  0);
        chk({tag, "_store_idx"}, 32'(store_idx), 0);
        chk({tag, "_seq1"},      32'(seq1),      0);
        chk({tag, "_seq2"},      32'(seq2),      0);
        chk({tag, "_depth"},     32'(depth),     0);
    endtask

    task automatic clear_counts(input int stall, input int gap);
        cnt_cmp = 0; cnt_rot = 0; cnt_store = 0; cnt_load = 0;
        stab_err = 0; seq_err = 0;
        stall_cnt = stall; ack_gap = gap; ack_wait = gap;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit to = 1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) begin
                to = 0;
                break;
            end
        end
        chk({tag, "_timeout"}, 32'(to), 0);
    endtask

    initial begin
        int saved;
        bit to;

        // ---- reset values
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        // ---- match on first compare (depth 0)
        tgt_len = 0;
        clear_counts(0, 0);
        pulse_start();
        wait_idle("t1", 200);
        chk("t1_depth", 32'(depth), 0);
        chk("t1_seq1",  32'(seq1), 0);
        chk("t1_seq2",  32'(seq2), 0);
        chk("t1_cmp",   cnt_cmp, 1);
        chk("t1_rot",   cnt_rot, 0);
        chk("t1_store", cnt_store, 5);
        chk("t1_seqerr", seq_err, 0);
        chk("t1_found", 32'(found), 1);
        chk("t1_fail",  32'(fail), 0);

        // ---- match only after X270
        tgt_len = 1; tgt[0] = 3'd2;
        clear_counts(0, 0);
        pulse_start();
        wait_idle("t2", 500);
        chk("t2_depth", 32'(depth), 1);
        chk("t2_seq1",  32'(seq1), 2);
        chk("t2_cmp",   cnt_cmp, 4);
        chk("t2_rot",   cnt_rot, 3);
        chk("t2_load",  cnt_load, 4);
        chk("t2_found", 32'(found), 1);

        // ---- match only for Y90 then Z180
        tgt_len = 2; tgt[0] = 3'd3; tgt[1] = 3'd7;
        clear_counts(0, 0);
        pulse_start();
        wait_idle("t3", 3000);
        chk("t3_depth", 32'(depth), 2);
        chk("t3_seq1",  32'(seq1), 3);
        chk("t3_seq2",  32'(seq2), 7);
        chk("t3_cmp",   cnt_cmp, 41);
        chk("t3_rot",   cnt_rot, 72);
        chk("t3_hist_len", hist_len, 2);
        chk("t3_first_rot",  32'(hist[0]), 3);
        chk("t3_second_rot", 32'(hist[1]), 7);
        chk("t3_found", 32'(found), 1);

        // ---- never matches: full exhaustion
        tgt_len = 3;
        clear_counts(0, 0);
        pulse_start();
        wait_idle("t4", 5000);
        chk("t4_cmp",   cnt_cmp, 73);
        chk("t4_rot",   cnt_rot, 136);
        chk("t4_load",  cnt_load, 73);
        chk("t4_store", cnt_store, 0);
        chk("t4_fail",  32'(fail), 1);
        chk("t4_found", 32'(found), 0);
        chk("t4_depth", 32'(depth), 2);
        chk("t4_seq1",  32'(seq1), 7);
        chk("t4_seq2",  32'(seq2), 7);

        // ---- stalled rot_ready, delayed store_ack, start while busy
        tgt_len = 1; tgt[0] = 3'd5;
        clear_counts(10, 3);
        pulse_start();
        chk("t5_fail_cleared", 32'(fail), 0);
        chk("t5_busy", 32'(busy), 1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle("t5", 1000);
        chk("t5_stable", stab_err, 0);
        chk("t5_store", cnt_store, 5);
        chk("t5_seqerr", seq_err, 0);
        chk("t5_cmp",   cnt_cmp, 7);
        chk("t5_seq1",  32'(seq1), 5);
        chk("t5_found", 32'(found), 1);

        // ---- reset during WAIT2 (candidate 0,1), stray rot_done afterwards
        tgt_len = 3;
        clear_counts(0, 0);
        pulse_start();
        to = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rot_valid && depth == 2'd2 && seq1 == 3'd0 && seq2 == 3'd1 && rot_code == 3'd1) begin
                to = 0;
                break;
            end
        end
        chk("t6_reach_timeout", 32'(to), 0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk_reset("t6");
        saved = cnt_cmp;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_rot_valid", 32'(rot_valid), 0);
        chk("t6_no_cmp", cnt_cmp, saved);

        // ---- reset during store beat 2
        tgt_len = 0;
        clear_counts(0, 2);
        pulse_start();
        to = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (store_req && store_idx == 3'd2) begin
                to = 0;
                break;
            end
        end
        chk("t7_reach_timeout", 32'(to), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("t7");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_idle_busy", 32'(busy), 0);
        chk("t7_idle_store_req", 32'(store_req), 0);

        // ---- normal search after reset
        tgt_len = 1; tgt[0] = 3'd1;
        clear_counts(0, 0);
        pulse_start();
        wait_idle("t8", 500);
        chk("t8_depth", 32'(depth), 1);
        chk("t8_seq1",  32'(seq1), 1);
        chk("t8_cmp",   cnt_cmp, 3);
        chk("t8_store", cnt_store, 5);
        chk("t8_found", 32'(found), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rot_search_ctrl
`default_nettype wire
